// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: id width and packed-bus slice helpers shared by the arbiter and its round-robin core.
package ram_port_arbiter_pkg;
  function automatic int idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  function automatic int lo(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant of the first masked requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter import ram_port_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IDW = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);
  int j;
  // scan from farthest to nearest so the candidate closest to ptr wins
  always_comb begin
    grant = '0;
    id = '0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j] & mask[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        id = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one RAM port among NREQ requesters, with lock and tagged read return.
module ram_port_arbiter import ram_port_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  parameter int widthad = 16,
  parameter int width = 32,
  localparam int IDW = idw(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*widthad-1:0] req_addr,
  input  logic [NREQ*width-1:0]   req_wdata,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [width-1:0]        rsp_data,
  output logic [widthad-1:0]      ram_address,
  output logic                    ram_wren,
  output logic [width-1:0]        ram_data,
  output logic                    ram_rden,
  input  logic [width-1:0]        ram_q
);
  logic [IDW-1:0] rr_ptr, lock_owner, gid;
  logic lock_active, issue, we, lock;
  logic [NREQ-1:0] mask, grant;
  logic [widthad-1:0] addr_hold;
  logic [width-1:0] data_hold;
  assign mask = lock_active ? NREQ'(1) << lock_owner : '1;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req(req_valid),
    .mask(mask),
    .ptr(rr_ptr),
    .grant(grant),
    .id(gid)
  );
  assign req_ready = rst_n ? grant : '0;
  assign issue = |(req_valid & req_ready);
  assign we = req_we[gid];
  assign lock = req_lock[gid];
  assign ram_wren = issue & we;
  assign ram_rden = issue & ~we;
  assign ram_address = issue ? req_addr[lo(int'(gid), widthad) +: widthad] : addr_hold;
  assign ram_data = issue ? req_wdata[lo(int'(gid), width) +: width] : data_hold;
  assign rsp_data = ram_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      lock_active <= 1'b0;
      lock_owner <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      rsp_valid <= ram_rden;
      if (ram_rden) rsp_id <= gid;
      if (issue) begin
        addr_hold <= ram_address;
        data_hold <= ram_data;
        lock_active <= lock;
        if (lock) lock_owner <= gid;
        else rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios against the arbiter driving a registered-address RAM model.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid, req_we, req_lock, req_ready;
  logic [31:0] req_addr;
  logic [127:0] req_wdata;
  logic rsp_valid, ram_wren, ram_rden;
  logic [1:0] rsp_id;
  logic [31:0] rsp_data, ram_data, ram_q;
  logic [7:0] ram_address, addr_q;
  logic [31:0] mem [256];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NREQ(4), .widthad(8), .width(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_q(ram_q)
  );

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    if (ram_rden) addr_q <= ram_address;
  end
  assign ram_q = mem[addr_q];

  task automatic clr;
    req_valid = '0;
    req_we = '0;
    req_lock = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic l,
                         input logic [7:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_we[i] = w;
    req_lock[i] = l;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    repeat (2) @(negedge clk);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    tests++; if (ram_wren !== 1'b0) begin fails++; $display("FAIL reset_wren got %b want 0", ram_wren); end
    tests++; if (ram_rden !== 1'b0) begin fails++; $display("FAIL reset_rden got %b want 0", ram_rden); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
  endtask

  task automatic test_write_read;
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL wr_ready got %b want 0001", req_ready); end
    tests++; if (ram_wren !== 1'b1 || ram_rden !== 1'b0) begin fails++; $display("FAIL wr_ctrl got wren=%b rden=%b want 1 0", ram_wren, ram_rden); end
    tests++; if (ram_address !== 8'h10 || ram_data !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_bus got %h/%h want 10/deadbeef", ram_address, ram_data); end
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    tests++; if (ram_rden !== 1'b1 || req_ready !== 4'b0001) begin fails++; $display("FAIL rd_issue got rden=%b ready=%b want 1 0001", ram_rden, req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_no_rsp got %b want 0", rsp_valid); end
    step();
    clr();
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin fails++; $display("FAIL rd_rsp got v=%b id=%0d want 1 0", rsp_valid, rsp_id); end
    tests++; if (rsp_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", rsp_data); end
    tests++; if (ram_wren !== 1'b0 || ram_rden !== 1'b0 || ram_address !== 8'h10) begin fails++; $display("FAIL idle_hold got wren=%b rden=%b addr=%h want 0 0 10", ram_wren, ram_rden, ram_address); end
    step();
  endtask

  task automatic test_fairness;
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'b0001 << (c % 4);
      @(negedge clk);
      tests++; if (req_ready !== exp_g) begin fails++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, exp_g); end
      if (c > 0) begin
        tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % 4)) begin fails++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d want 1 %0d", c, rsp_valid, rsp_id, (c - 1) % 4); end
      end
      step();
    end
    clr();
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rr_last got v=%b id=%0d d=%h want 1 3 deadbeef", rsp_valid, rsp_id, rsp_data); end
    step();
  endtask

  task automatic test_sparse;
    do_reset();
    set_req(2, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    set_req(3, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL sparse_first got %b want 0100", req_ready); end
    step();
    clr();
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000 || rsp_id !== 2'd2) begin fails++; $display("FAIL sparse_idle got ready=%b id=%0d want 0000 2", req_ready, rsp_id); end
    step();
    req_valid = 4'b1100;
    @(negedge clk);
    tests++; if (req_ready !== 4'b1000 || rsp_valid !== 1'b0) begin fails++; $display("FAIL sparse_ptr_hold got ready=%b v=%b want 1000 0", req_ready, rsp_valid); end
    step();
    @(negedge clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL sparse_wrap got %b want 0100", req_ready); end
    step();
    clr();
  endtask

  task automatic test_lock_rmw;
    do_reset();
    set_req(1, 1'b1, 1'b0, 1'b1, 8'h10, 32'h0);
    @(negedge clk);
    tests++; if (req_ready !== 4'b0010 || ram_rden !== 1'b1) begin fails++; $display("FAIL lock_rd got ready=%b rden=%b want 0010 1", req_ready, ram_rden); end
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 8'h10, 32'h0);
    set_req(2, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    set_req(3, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000 || ram_rden !== 1'b0) begin fails++; $display("FAIL lock_block1 got ready=%b rden=%b want 0000 0", req_ready, ram_rden); end
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lock_rsp got v=%b id=%0d d=%h want 1 1 deadbeef", rsp_valid, rsp_id, rsp_data); end
    step();
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL lock_block2 got %b want 0000", req_ready); end
    step();
    set_req(1, 1'b1, 1'b1, 1'b0, 8'h10, 32'h12345678);
    @(negedge clk);
    tests++; if (req_ready !== 4'b0010 || ram_wren !== 1'b1 || ram_data !== 32'h12345678) begin fails++; $display("FAIL lock_wr got ready=%b wren=%b d=%h want 0010 1 12345678", req_ready, ram_wren, ram_data); end
    step();
    req_valid[1] = 1'b0;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL unlock_next got %b want 0100", req_ready); end
    step();
    req_valid[2] = 1'b0;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h12345678) begin fails++; $display("FAIL rmw_readback got v=%b id=%0d d=%h want 1 2 12345678", rsp_valid, rsp_id, rsp_data); end
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL unlock_rr got %b want 1000", req_ready); end
    step();
    clr();
  endtask

  task automatic test_reset_mid_lock;
    do_reset();
    set_req(1, 1'b1, 1'b0, 1'b1, 8'h10, 32'h0);
    @(negedge clk);
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL midlock_grant got %b want 0010", req_ready); end
    step();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL midlock_pending got %b want 1", rsp_valid); end
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
    rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || ram_rden !== 1'b0) begin fails++; $display("FAIL midlock_async got v=%b ready=%b rden=%b want 0 0000 0", rsp_valid, req_ready, ram_rden); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL midlock_release got %b want 0001", req_ready); end
    step();
    clr();
  endtask

  initial begin
    clr();
    req_addr = '0;
    req_wdata = '0;
    test_reset();
    test_write_read();
    test_fairness();
    test_sparse();
    test_lock_rmw();
    test_reset_mid_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
